// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle for the Simulink-to-PPC read-back register.
interface opb_register_simulink2ppc_if;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// Captures a word from the user fabric and exposes it, with fresh/overrun
// status, an update counter and a hold control, as an OPB read-back register.
module opb_register_simulink2ppc #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   opb_register_simulink2ppc_if.slave  bus,
   input  logic [31:0]                 user_data_in,
   input  logic                        user_valid
);

   localparam int unsigned aw = C_OPB_AWIDTH;
   localparam int unsigned dw = C_OPB_DWIDTH;
   localparam logic [aw-1:0] span = aw'(C_HIGHADDR - C_BASEADDR);
   localparam logic [5:0] off_data   = 6'd0;
   localparam logic [5:0] off_status = 6'd1;
   localparam logic [5:0] off_ctrl   = 6'd2;
   localparam logic [5:0] off_clear  = 6'd3;

   typedef enum logic {st_idle, st_ack} state_t;

   state_t        state_q, state_d;
   logic          ack_q, ack_d;
   logic [dw-1:0] dbus_q, dbus_d;
   logic          req;

   logic [31:0] data_q;
   logic [15:0] count_q;
   logic        fresh_q, overrun_q, hold_q;

   logic [aw-1:0] rel;
   logic          hit;
   logic [5:0]    off;
   logic [dw-1:0] rd_mux;
   logic          capture, rd_data, wr_ctrl, wr_clear;
   logic          unused_ok;

   // Modular distance from base covers base <= addr <= high in one compare.
   assign rel = aw'(bus.OPB_ABus - C_BASEADDR);
   assign hit = (rel <= span);
   assign off = bus.OPB_ABus[24:29];

   always_comb begin
      rd_mux = '0;
      case (off)
         off_data:   rd_mux = dw'(data_q);
         off_status: rd_mux = dw'({fresh_q, overrun_q, 13'd0, hold_q, count_q});
         off_ctrl:   rd_mux = dw'({31'd0, hold_q});
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q <= st_idle;
         ack_q   <= 1'b0;
         dbus_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         dbus_q  <= dbus_d;
      end
   end

   // Select is only honoured in idle, so a held select re-arms after the ack.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      dbus_d  = '0;
      req     = 1'b0;
      case (state_q)
         st_idle: begin
            if (bus.OPB_select && hit) begin
               req     = 1'b1;
               state_d = st_ack;
               ack_d   = 1'b1;
               if (bus.OPB_RNW) dbus_d = rd_mux;
            end
         end
         st_ack:  state_d = st_idle;
         default: state_d = st_idle;
      endcase
   end

   assign capture  = user_valid && !hold_q;
   assign rd_data  = req && bus.OPB_RNW && (off == off_data);
   assign wr_ctrl  = req && !bus.OPB_RNW && (off == off_ctrl) && bus.OPB_BE[3];
   assign wr_clear = req && !bus.OPB_RNW && (off == off_clear) && bus.OPB_BE[3]
                     && bus.OPB_DBus[31];

   // A clear and a capture on the same edge leave COUNT at 1 and OVERRUN at 0.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         data_q    <= '0;
         count_q   <= '0;
         fresh_q   <= 1'b0;
         overrun_q <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         if (capture) data_q <= user_data_in;

         if (wr_clear)     count_q <= capture ? 16'd1 : 16'd0;
         else if (capture) count_q <= count_q + 16'd1;

         if (wr_clear)                overrun_q <= 1'b0;
         else if (capture && fresh_q) overrun_q <= 1'b1;

         if (capture)      fresh_q <= 1'b1;
         else if (rd_data) fresh_q <= 1'b0;

         if (wr_ctrl) hold_q <= bus.OPB_DBus[31];
      end
   end

   assign bus.Sl_DBus    = 32'(dbus_q);
   assign bus.Sl_xferAck = ack_q;
   assign bus.Sl_errAck  = 1'b0;
   assign bus.Sl_retry   = 1'b0;
   assign bus.Sl_toutSup = 1'b0;

   assign unused_ok = &{1'b0, bus.OPB_seqAddr, bus.OPB_DBus[0:30], bus.OPB_BE[0:2],
                        (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc with hand-computed expectations.
module tb_opb_register_simulink2ppc;

   logic        clk;
   logic        rst_n;
   logic [31:0] user_data_in;
   logic        user_valid;
   logic [31:0] r;
   int          total;
   int          bad;

   opb_register_simulink2ppc_if bus ();

   opb_register_simulink2ppc dut (
      .OPB_Clk      (clk),
      .OPB_Rst_n    (rst_n),
      .bus          (bus),
      .user_data_in (user_data_in),
      .user_valid   (user_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered and left at posedge+1; optional user capture in the select cycle.
   task automatic opb_xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic cap,
                           input logic [31:0] cdata, output logic [31:0] rdata);
      bus.OPB_select = 1'b1;
      bus.OPB_ABus   = addr;
      bus.OPB_RNW    = rnw;
      bus.OPB_BE     = be;
      bus.OPB_DBus   = rnw ? 32'h0 : wdata;
      user_valid     = cap;
      user_data_in   = cdata;
      @(posedge clk); #1;
      chk("ack_high", 32'(bus.Sl_xferAck), 32'h1);
      rdata = bus.Sl_DBus;
      bus.OPB_select = 1'b0;
      bus.OPB_RNW    = 1'b1;
      bus.OPB_DBus   = 32'h0;
      user_valid     = 1'b0;
      @(posedge clk); #1;
      chk("ack_low", 32'(bus.Sl_xferAck), 32'h0);
      chk("dbus_idle", bus.Sl_DBus, 32'h0);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      opb_xfer(1'b1, addr, 4'hF, 32'h0, 1'b0, 32'h0, d);
      chk(tag, d, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
      logic [31:0] d;
      opb_xfer(1'b0, addr, be, wdata, 1'b0, 32'h0, d);
   endtask

   task automatic cap(input logic [31:0] v);
      user_valid   = 1'b1;
      user_data_in = v;
      @(posedge clk); #1;
      user_valid   = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      user_valid   = 1'b0;
      user_data_in = 32'h0;
      bus.OPB_select  = 1'b0;
      bus.OPB_ABus    = 32'h0;
      bus.OPB_BE      = 4'h0;
      bus.OPB_DBus    = 32'h0;
      bus.OPB_RNW     = 1'b1;
      bus.OPB_seqAddr = 1'b0;
      #1;
      chk("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
      chk("rst_dbus", bus.Sl_DBus, 32'h0);
      chk("errack_retry_tout", 32'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      rd("reset_data", 32'h00, 32'h0000_0000);
      rd("reset_status", 32'h04, 32'h0000_0000);

      cap(32'hDEAD_BEEF);
      rd("status_fresh", 32'h04, 32'h8000_0001);
      rd("data_beef", 32'h00, 32'hDEAD_BEEF);
      rd("status_read_clears_fresh", 32'h04, 32'h0000_0001);

      cap(32'h11);
      cap(32'h22);
      rd("status_overrun", 32'h04, 32'hC000_0003);
      wr(32'h0C, 4'hE, 32'h1);
      rd("clear_be3_low_ignored", 32'h04, 32'hC000_0003);
      wr(32'h0C, 4'hF, 32'h1);
      rd("status_after_clear", 32'h04, 32'h8000_0000);
      rd("data_22", 32'h00, 32'h0000_0022);

      wr(32'h08, 4'hF, 32'h1);
      rd("ctrl_hold_set", 32'h08, 32'h0000_0001);
      cap(32'h55);
      rd("hold_data_kept", 32'h00, 32'h0000_0022);
      rd("hold_status", 32'h04, 32'h0001_0000);
      wr(32'h08, 4'hF, 32'h0);
      wr(32'h08, 4'hE, 32'h1);
      rd("ctrl_be3_low_ignored", 32'h08, 32'h0000_0000);
      rd("status_idle", 32'h04, 32'h0000_0000);
      rd("clear_reads_zero", 32'h0C, 32'h0000_0000);
      rd("unmapped_reads_zero", 32'h10, 32'h0000_0000);
      wr(32'h00, 4'hF, 32'hFFFF_FFFF);
      rd("data_ro", 32'h00, 32'h0000_0022);

      bus.OPB_select = 1'b1;
      bus.OPB_ABus   = 32'h100;
      bus.OPB_RNW    = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("outside_no_ack", 32'(bus.Sl_xferAck), 32'h0);
         chk("outside_dbus", bus.Sl_DBus, 32'h0);
      end
      bus.OPB_select = 1'b0;

      opb_xfer(1'b1, 32'h00, 4'hF, 32'h0, 1'b1, 32'h99, r);
      chk("read_cap_old_word", r, 32'h0000_0022);
      rd("read_cap_status", 32'h04, 32'h8000_0001);
      opb_xfer(1'b1, 32'h00, 4'hF, 32'h0, 1'b1, 32'hAA, r);
      chk("read_cap_old_99", r, 32'h0000_0099);
      rd("read_cap_overrun", 32'h04, 32'hC000_0002);

      opb_xfer(1'b0, 32'h0C, 4'hF, 32'h1, 1'b1, 32'hBB, r);
      rd("clear_cap_status", 32'h04, 32'h8000_0001);
      opb_xfer(1'b0, 32'h08, 4'hF, 32'h1, 1'b1, 32'hCC, r);
      rd("hold_cap_status", 32'h04, 32'hC001_0002);
      rd("hold_cap_data", 32'h00, 32'h0000_00CC);
      rd("hold_cap_status2", 32'h04, 32'h4001_0002);
      wr(32'h08, 4'hF, 32'h0);
      wr(32'h0C, 4'hF, 32'h1);
      rd("cleared_again", 32'h04, 32'h0000_0000);

      user_valid   = 1'b1;
      user_data_in = 32'h1234_5678;
      repeat (65535) @(posedge clk);
      #1;
      user_valid = 1'b0;
      rd("count_ffff", 32'h04, 32'hC000_FFFF);
      cap(32'h0BAD_F00D);
      rd("count_wrap", 32'h04, 32'hC000_0000);
      rd("data_after_wrap", 32'h00, 32'h0BAD_F00D);

      bus.OPB_select = 1'b1;
      bus.OPB_ABus   = 32'h04;
      bus.OPB_RNW    = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_ack", 32'(bus.Sl_xferAck), 32'h1);
      chk("pre_rst_dbus", bus.Sl_DBus, 32'h4000_0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_in_ack_ack", 32'(bus.Sl_xferAck), 32'h0);
      chk("rst_in_ack_dbus", bus.Sl_DBus, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_held_no_ack", 32'(bus.Sl_xferAck), 32'h0);
      end
      bus.OPB_select = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      bus.OPB_select = 1'b1;
      bus.OPB_ABus   = 32'h00;
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ack", 32'(bus.Sl_xferAck), 32'h0);
      @(posedge clk); #1;
      chk("rst_mid_no_ack", 32'(bus.Sl_xferAck), 32'h0);
      chk("rst_mid_dbus", bus.Sl_DBus, 32'h0);
      bus.OPB_select = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      rd("post_rst_status", 32'h04, 32'h0000_0000);
      rd("post_rst_data", 32'h00, 32'h0000_0000);
      rd("post_rst_ctrl", 32'h08, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
